// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a gate
// window of SYS_FREQUENCY clk_in cycles and reports the count in Hz.
// Optional build macro: FREQ_METER_RANGE_CHECK_EN enables the F_MIN..F_MAX
// range comparator driving freq_ok; without it freq_ok is tied high.
//
// state | meaning
// IDLE  | measurement disabled, counters held at zero
// COUNT | gate window running, rising edges being counted
module freq_meter #(
  parameter logic [25:0] SYS_FREQUENCY = 26'd50_000_000,
  parameter logic [25:0] F_MIN         = 26'd1,
  parameter logic [25:0] F_MAX         = 26'd25_000_000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        en,
  input  logic        sig_in,
  output logic [25:0] freq,
  output logic        valid,
  output logic        no_signal,
  output logic        freq_ok
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        s1_q, s2_q, s3_q;
  logic        s1_d, s2_d, s3_d;
  logic [25:0] gate_cnt_q, gate_cnt_d;
  logic [25:0] edge_cnt_q, edge_cnt_d;
  logic [25:0] freq_q, freq_d;
  logic        valid_q, valid_d;
  logic        no_signal_q, no_signal_d;
  logic        edge_det;
  logic        terminal;
  logic [25:0] edge_sum;

`ifdef FREQ_METER_RANGE_CHECK_EN
  logic        freq_ok_q, freq_ok_d;
  logic        in_range;
`else
  logic        unused_range_params;
`endif

  // Synchronizer, edge detect and window bookkeeping derived from current state
  always_comb begin
    s1_d     = sig_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    edge_det = s2_q & ~s3_q;
    // An edge seen in the terminal cycle still belongs to the closing window
    edge_sum = edge_cnt_q + {25'd0, edge_det};
    terminal = (gate_cnt_q == (SYS_FREQUENCY - 26'd1));
  end

`ifdef FREQ_METER_RANGE_CHECK_EN
  // Range comparison on the result being published this cycle
  always_comb begin
    in_range = (edge_sum >= F_MIN) && (edge_sum <= F_MAX);
  end
`else
  assign unused_range_params = ^{F_MIN, F_MAX};
`endif

  // Next-state and datapath updates for the gate FSM
  always_comb begin
    state_d     = state_q;
    gate_cnt_d  = gate_cnt_q;
    edge_cnt_d  = edge_cnt_q;
    freq_d      = freq_q;
    valid_d     = 1'b0;
    no_signal_d = no_signal_q;
`ifdef FREQ_METER_RANGE_CHECK_EN
    freq_ok_d   = freq_ok_q;
`endif
    case (state_q)
      IDLE: begin
        gate_cnt_d = 26'd0;
        edge_cnt_d = 26'd0;
        if (en) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!en) begin
          // Abandon the partial window; published results stay as they were
          state_d    = IDLE;
          gate_cnt_d = 26'd0;
          edge_cnt_d = 26'd0;
        end else if (terminal) begin
          freq_d      = edge_sum;
          valid_d     = 1'b1;
          no_signal_d = (edge_sum == 26'd0);
`ifdef FREQ_METER_RANGE_CHECK_EN
          freq_ok_d   = in_range;
`endif
          gate_cnt_d  = 26'd0;
          edge_cnt_d  = 26'd0;
        end else begin
          gate_cnt_d = gate_cnt_q + 26'd1;
          edge_cnt_d = edge_sum;
        end
      end
      default: begin
        state_d    = IDLE;
        gate_cnt_d = 26'd0;
        edge_cnt_d = 26'd0;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      gate_cnt_q  <= 26'd0;
      edge_cnt_q  <= 26'd0;
      freq_q      <= 26'd0;
      valid_q     <= 1'b0;
      no_signal_q <= 1'b0;
`ifdef FREQ_METER_RANGE_CHECK_EN
      freq_ok_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      gate_cnt_q  <= gate_cnt_d;
      edge_cnt_q  <= edge_cnt_d;
      freq_q      <= freq_d;
      valid_q     <= valid_d;
      no_signal_q <= no_signal_d;
`ifdef FREQ_METER_RANGE_CHECK_EN
      freq_ok_q   <= freq_ok_d;
`endif
    end
  end

  assign freq      = freq_q;
  assign valid     = valid_q;
  assign no_signal = no_signal_q;
`ifdef FREQ_METER_RANGE_CHECK_EN
  assign freq_ok   = freq_ok_q;
`else
  assign freq_ok   = 1'b1;
`endif

endmodule
